// File: rtl/user_wb_io_regs.sv
// Wishbone classic register block for the user GPIOs, input edge interrupts,
// a 16-bit down-counting timer and a software interrupt.
module user_wb_io_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned NIO       = 16
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_ni,
    input  logic           wbs_cyc_i,
    input  logic           wbs_stb_i,
    input  logic           wbs_we_i,
    input  logic [3:0]     wbs_sel_i,
    input  logic [31:0]    wbs_adr_i,
    input  logic [31:0]    wbs_dat_i,
    output logic           wbs_ack_o,
    output logic [31:0]    wbs_dat_o,
    input  logic [NIO-1:0] io_in,
    output logic [NIO-1:0] io_out,
    output logic [NIO-1:0] io_oeb,
    output logic [2:0]     irq
);

    localparam int unsigned SW   = NIO + 1;
    localparam int unsigned TW   = 16;
    localparam int unsigned OFFW = 6;

    localparam logic [OFFW-1:0] OFF_OUT   = 6'h00;
    localparam logic [OFFW-1:0] OFF_OEB   = 6'h01;
    localparam logic [OFFW-1:0] OFF_IN    = 6'h02;
    localparam logic [OFFW-1:0] OFF_IEN   = 6'h03;
    localparam logic [OFFW-1:0] OFF_STAT  = 6'h04;
    localparam logic [OFFW-1:0] OFF_TLOAD = 6'h05;
    localparam logic [OFFW-1:0] OFF_TCTRL = 6'h06;
    localparam logic [OFFW-1:0] OFF_TCNT  = 6'h07;
    localparam logic [OFFW-1:0] OFF_SWI   = 6'h08;

    logic [NIO-1:0] out_q,   out_d;
    logic [NIO-1:0] oeb_q,   oeb_d;
    logic [NIO-1:0] sync1_q, sync2_q, sync3_q;
    logic [SW-1:0]  ien_q,   ien_d;
    logic [SW-1:0]  stat_q,  stat_d;
    logic [TW-1:0]  tload_q, tload_d;
    logic [1:0]     tctrl_q, tctrl_d;
    logic [TW-1:0]  tcnt_q,  tcnt_d;
    logic           swi_q,   swi_d;
    logic           ack_q,   ack_d;
    logic [31:0]    dat_q,   dat_d;
    logic [2:0]     irq_q,   irq_d;

    logic [OFFW-1:0] off_c;
    logic [31:0]     mask_c;
    logic [31:0]     rdata_c;
    logic [SW-1:0]   stat_set_c;
    logic [SW-1:0]   stat_clr_c;
    logic            req_c;
    logic            wr_c;
    logic            expire_c;
    logic            unused_c;

    assign unused_c = ^wbs_adr_i[1:0];

    // Byte-lane merge of write data into the current register contents.
    function automatic logic [31:0] wmerge(input logic [31:0] old,
                                           input logic [31:0] dat,
                                           input logic [31:0] mask);
        return (old & ~mask) | (dat & mask);
    endfunction

    always_comb begin
        off_c    = wbs_adr_i[7:2];
        mask_c   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
        req_c    = wbs_cyc_i && wbs_stb_i && !ack_q && (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
        wr_c     = req_c && wbs_we_i;
        expire_c = tctrl_q[0] && (tcnt_q == '0);

        out_d      = out_q;
        oeb_d      = oeb_q;
        ien_d      = ien_q;
        tload_d    = tload_q;
        tctrl_d    = tctrl_q;
        tcnt_d     = tcnt_q;
        swi_d      = swi_q;
        stat_clr_c = '0;
        stat_set_c = {expire_c, sync2_q & ~sync3_q};
        rdata_c    = '0;

        // Free-running timer; a TCTRL write below overrides run and count.
        if (tctrl_q[0]) begin
            if (expire_c) begin
                if (tctrl_q[1]) begin
                    tcnt_d = tload_q;
                end else begin
                    tcnt_d     = '0;
                    tctrl_d[0] = 1'b0;
                end
            end else begin
                tcnt_d = tcnt_q - TW'(1);
            end
        end

        if (wr_c) begin
            case (off_c)
                OFF_OUT:   out_d   = NIO'(wmerge(32'(out_q), wbs_dat_i, mask_c));
                OFF_OEB:   oeb_d   = NIO'(wmerge(32'(oeb_q), wbs_dat_i, mask_c));
                OFF_IEN:   ien_d   = SW'(wmerge(32'(ien_q), wbs_dat_i, mask_c));
                OFF_STAT:  stat_clr_c = SW'(wbs_dat_i & mask_c);
                OFF_TLOAD: tload_d = TW'(wmerge(32'(tload_q), wbs_dat_i, mask_c));
                OFF_TCTRL: begin
                    if (wbs_sel_i[0]) begin
                        tctrl_d = wbs_dat_i[1:0];
                        tcnt_d  = wbs_dat_i[0] ? tload_q : tcnt_q;
                    end
                end
                OFF_SWI:   if (wbs_sel_i[0]) swi_d = wbs_dat_i[0];
                default:   ;
            endcase
        end

        case (off_c)
            OFF_OUT:   rdata_c = 32'(out_q);
            OFF_OEB:   rdata_c = 32'(oeb_q);
            OFF_IN:    rdata_c = 32'(sync2_q);
            OFF_IEN:   rdata_c = 32'(ien_q);
            OFF_STAT:  rdata_c = 32'(stat_q);
            OFF_TLOAD: rdata_c = 32'(tload_q);
            OFF_TCTRL: rdata_c = 32'(tctrl_q);
            OFF_TCNT:  rdata_c = 32'(tcnt_q);
            OFF_SWI:   rdata_c = 32'(swi_q);
            default:   rdata_c = '0;
        endcase

        // Set wins over a simultaneous write-1-to-clear.
        stat_d = (stat_q & ~stat_clr_c) | stat_set_c;
        irq_d  = {swi_q, stat_q[SW-1] & ien_q[SW-1], |(stat_q[NIO-1:0] & ien_q[NIO-1:0])};
        ack_d  = req_c;
        dat_d  = (req_c && !wbs_we_i) ? rdata_c : '0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            out_q   <= '0;
            oeb_q   <= '1;
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            ien_q   <= '0;
            stat_q  <= '0;
            tload_q <= '0;
            tctrl_q <= '0;
            tcnt_q  <= '0;
            swi_q   <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            irq_q   <= '0;
        end else begin
            out_q   <= out_d;
            oeb_q   <= oeb_d;
            sync1_q <= io_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            ien_q   <= ien_d;
            stat_q  <= stat_d;
            tload_q <= tload_d;
            tctrl_q <= tctrl_d;
            tcnt_q  <= tcnt_d;
            swi_q   <= swi_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            irq_q   <= irq_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign io_out    = out_q;
    assign io_oeb    = oeb_q;
    assign irq       = irq_q;

endmodule

// File: doc/user_wb_io_regs.md
# user_wb_io_regs

Wishbone classic responder that sits inside the user project area, on the wrapper's `wbs_*` port group, driven by the management SoC as the bus initiator. It exposes the 16 user GPIOs through registers: output data, output-enable, and synchronized input. It also provides input rising-edge interrupt flags, a 16-bit down-counting timer and a software interrupt, all on `irq[2:0]`. One transaction completes every two cycles; no wait-state stretching beyond that.

## Interface
- `BASE_ADDR`, 32'h3000_0000: window base. Decode is `wbs_adr_i[31:8] == BASE_ADDR[31:8]`. Register offset is `wbs_adr_i[7:2]`.
- `NIO`, 16: GPIO width. Fixed at 16 for this revision; other values are unsupported.

Ports:
- `wb_clk_i`  in  1  single clock for all logic.
- `wb_rst_ni`  in  1  reset, asynchronous, active-low.
- `wbs_cyc_i`  in  1  bus cycle.
- `wbs_stb_i`  in  1  strobe.
- `wbs_we_i`  in  1  1 = write.
- `wbs_sel_i`  in  4  byte enables.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  acknowledge, one-cycle pulse.
- `wbs_dat_o`  out  32  read data.
- `io_in`  in  16  pad inputs (asynchronous).
- `io_out`  out  16  pad outputs.
- `io_oeb`  out  16  pad output-enable, active-low.
- `irq`  out  3  interrupts to SoC.

## Operation
Register map (offset: name, access, reset):
- 0x00 `OUT`[15:0], RW, 0. Drives `io_out`.
- 0x04 `OEB`[15:0], RW, 16'hFFFF (all pins are inputs).
- 0x08 `IN`[15:0], RO. Two-flop synchronized `io_in`.
- 0x0C `IEN`: [15:0] edge-enable, [16] timer-enable. RW, 0.
- 0x10 `STAT`: [15:0] edge flags, [16] timer flag. Write-1-to-clear, 0.
- 0x14 `TLOAD`[15:0], RW, 0.
- 0x18 `TCTRL`: [0] run, [1] auto-reload. RW, 0.
- 0x1C `TCNT`[15:0], RO, 0.
- 0x20 `SWI`[0], RW, 0.

Access rules:
- Writes honour `wbs_sel_i` per byte. Bits outside a register's width read as 0 and ignore writes.
- In-window, unmapped offsets are acked; they read 0 and ignore writes.
- Out-of-window accesses are never acked. The interconnect times them out; this block does nothing further.

Edge flags:
- `STAT[i]` sets when the synchronized input goes 0 to 1, compared against a third delay flop.
- Flags set regardless of `IEN`; `IEN` only gates the interrupt.

Timer:
- Writing `TCTRL` with run=1 loads `TCNT` from `TLOAD`. This applies even when run was already 1.
- While run=1, `TCNT` decrements each cycle.
- When `TCNT`==0 and run=1:
  - `STAT[16]` sets.
  - With auto-reload=1, `TCNT` reloads from `TLOAD`.
  - With auto-reload=0, run clears and `TCNT` holds 0.
- Writing run=0 freezes `TCNT`.

Interrupts (all registered):
- `irq[0]` = |(`STAT[15:0]` & `IEN[15:0]`).
- `irq[1]` = `STAT[16]` & `IEN[16]`.
- `irq[2]` = `SWI[0]`.

Simultaneous events:
- A set event and a W1C of the same bit in the same cycle: the bit stays set.
- A `TCTRL` write and a timer expiry in the same cycle: the write wins for run and `TCNT`, and `STAT[16]` still sets.

## Timing
- Request is sampled on the edge where `cyc&stb&!wbs_ack_o` = 1, in window. `wbs_ack_o` is 1 for exactly the next cycle, then 0, so the maximum rate is 1 transfer per 2 cycles.
- Write data is committed on the same edge that raises ack.
- `wbs_dat_o` is registered and valid while ack=1; it is 0 otherwise.
- `cyc` or `stb` dropping while ack is pending does not cancel the ack. The initiator ignores it.
- `io_out`/`io_oeb` change one edge after the write edge, i.e. they are visible in the ack cycle.
- Input latency:
  - A pin change is visible in `IN` after 2 edges.
  - `STAT` sets after 3 edges.
  - `irq[0]` rises after 4 edges.
- Timer: `TLOAD`=N with run written gives `STAT[16]` set N+1 cycles after the write commit edge. N=0 expires on the first cycle.
- Reset (asynchronous assert, mid-transaction included): every register goes to its reset value immediately.
  - `wbs_ack_o`=0, `wbs_dat_o`=0, `io_out`=0, `io_oeb`=16'hFFFF, `irq`=0.
  - Any pending ack is dropped.

## Test plan
- Reset, then read 0x04 and 0x00 → 0x0000FFFF and 0x0. `io_oeb`=16'hFFFF, `irq`=0, and ack arrives exactly 1 cycle after stb.
- Write `OUT`=0xA5A5 with sel=4'b0001, then read → 0x000000A5. `io_out`=0x00A5 in the ack cycle.
- Drive `io_in[3]` 0→1 with `IEN[3]`=1 → `STAT`=0x8 at edge 3 and `irq[0]`=1 at edge 4. W1C 0x8 → `irq[0]` 0. Hold the pin high → no re-set.
- `TLOAD`=5, `TCTRL`=3, `IEN[16]`=1 → `irq[1]` pulses every 6 cycles of `STAT` set. W1C in the same cycle as expiry → `STAT[16]` stays 1.
- Access offset 0x3C → acked, reads 0. Access `BASE_ADDR`+0x100 → no ack for 16 cycles.
- Assert `wb_rst_ni`=0 in the cycle between stb and ack → no ack, all outputs at reset values. Release, then `SWI`=1 → `irq[2]`=1.
